// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_pkg
// Description : Shared types and constants for the shared "1101" detector
//               scheduler: FSM states, detector state codes, match pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    // Detector state as seen on the (qa,qb) T flip-flop pair
    typedef enum logic [1:0] {
        DET_S0 = 2'b00,
        DET_S1 = 2'b01,
        DET_S3 = 2'b10,
        DET_S2 = 2'b11
    } det_state_e;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage
`default_nettype wire

// File: rtl/seq_detect_core_1101.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_core_1101
// Description : Bit-serial overlapping "1101" Mealy detector built from two
//               T flip-flops; match is combinational on state and input.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_core_1101
    import seq_detect_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       in,
    output logic       match,
    output det_state_e state
);

    logic qa_q, qa_d;
    logic qb_q, qb_d;
    logic ta, tb;

    // Toggle terms derived from the S0..S3 transition table for this encoding
    always_comb begin
        ta   = (qa_q ^ qb_q) & (qa_q | in);
        tb   = qb_q ^ in;
        qa_d = qa_q;
        qb_d = qb_q;
        if (clear) begin
            {qa_d, qb_d} = DET_S0;
        end else if (enable) begin
            qa_d = qa_q ^ ta;
            qb_d = qb_q ^ tb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qa_q <= 1'b0;
            qb_q <= 1'b0;
        end else begin
            qa_q <= qa_d;
            qb_q <= qb_d;
        end
    end

    assign state = det_state_e'({qa_q, qb_q});
    assign match = (state == DET_S3) && (in == PATTERN[0]);

endmodule
`default_nettype wire

// File: rtl/seq_detect_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_scheduler
// Description : Round-robin shares one "1101" detector between N_REQ
//               requesters; streams the granted word MSB-first through it.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_scheduler
    import seq_detect_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 16,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] istream,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        grant_id,
    output logic [WIDTH-1:0]       ostream
);

    localparam int              CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [ID_W:0]   N_REQ_W = (ID_W+1)'(N_REQ);

    sched_state_e     state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] ostream_q, ostream_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  gid_q, gid_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] rot;
    logic [ID_W:0]    sel_sum;
    logic [ID_W-1:0]  sel;
    logic             sel_valid;

    logic       det_clear, det_enable, det_in, det_match, match_bit;
    det_state_e det_state;

    // Rotate requests so bit 0 is the pointer position; lowest set bit wins
    always_comb begin
        rot       = N_REQ'({req, req} >> ptr_q);
        sel_valid = 1'b0;
        sel_sum   = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (rot[k]) begin
                sel_valid = 1'b1;
                sel_sum   = {1'b0, ptr_q} + (ID_W+1)'(k);
            end
        end
        if (sel_sum >= N_REQ_W) begin
            sel_sum = sel_sum - N_REQ_W;
        end
        sel = sel_sum[ID_W-1:0];
    end

    always_comb begin
        ack = '0;
        if ((state_q == ST_IDLE) && sel_valid && !reset) begin
            ack = N_REQ'(1) << sel;
        end
    end

    assign det_in    = word_q[cnt_q];
    assign match_bit = det_match && (det_state == DET_S3);

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        ostream_d  = ostream_q;
        cnt_d      = cnt_q;
        gid_d      = gid_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        det_clear  = 1'b0;
        det_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    for (int k = 0; k < N_REQ; k++) begin
                        if (sel == ID_W'(k)) begin
                            word_d = istream[k*WIDTH +: WIDTH];
                        end
                    end
                    gid_d     = sel;
                    busy_d    = 1'b1;
                    ostream_d = '0;
                    det_clear = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = CNT_W'(WIDTH-1);
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                det_enable       = 1'b1;
                ostream_d[cnt_q] = match_bit;
                cnt_d            = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_d   = (gid_q == ID_W'(N_REQ-1)) ? '0 : gid_q + 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            ostream_q <= '0;
            cnt_q     <= '0;
            gid_q     <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            ostream_q <= ostream_d;
            cnt_q     <= cnt_d;
            gid_q     <= gid_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
        end
    end

    seq_detect_core_1101 u_core (
        .clk    (clk),
        .reset  (reset),
        .clear  (det_clear),
        .enable (det_enable),
        .in     (det_in),
        .match  (det_match),
        .state  (det_state)
    );

    assign busy     = busy_q;
    assign done     = (state_q == ST_DONE);
    assign grant_id = gid_q;
    assign ostream  = ostream_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_scheduler
// Description : Self-checking bench: directed scenarios plus random requests
//               against a sliding-window / round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_scheduler;

    localparam int N_REQ = 2;
    localparam int WIDTH = 16;
    localparam int ID_W  = 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] istream;
    logic [N_REQ-1:0]       ack;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        grant_id;
    logic [WIDTH-1:0]       ostream;

    always #5 clk = ~clk;

    seq_detect_scheduler #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .istream  (istream),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .grant_id (grant_id),
        .ostream  (ostream)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Match flag i is set when the four bits ending at bit i (MSB-first) spell 1101
    function automatic logic [WIDTH-1:0] ref_detect(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i <= WIDTH-4; i++) begin
            if (w[i +: 4] == 4'b1101) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Reference model state
    int               cyc       = 0;
    bit               job_on    = 0;
    int               done_at   = 0;
    int               rr        = 0;
    int               exp_id    = 0;
    int               pick;
    int               jobs_done = 0;
    logic [WIDTH-1:0] exp_word;
    logic [N_REQ-1:0] ack_seen  = '0;
    logic [N_REQ-1:0] hold_req  = '0;

    always @(negedge clk) begin
        if (reset) begin
            check_val("rst_ack", ack, 0);
            check_val("rst_busy", busy, 0);
            check_val("rst_done", done, 0);
            check_val("rst_gid", grant_id, 0);
            check_val("rst_ostream", ostream, 0);
            job_on   = 0;
            rr       = 0;
            ack_seen = '0;
        end else begin
            cyc++;
            if (!job_on) begin
                check_val("idle_busy", busy, 0);
                check_val("idle_done", done, 0);
                pick = -1;
                for (int k = 0; k < N_REQ; k++) begin
                    if (pick < 0 && req[(rr + k) % N_REQ]) pick = (rr + k) % N_REQ;
                end
                if (pick >= 0) begin
                    check_val("ack_grant", ack, 1 << pick);
                    exp_word       = istream[pick*WIDTH +: WIDTH];
                    exp_id         = pick;
                    done_at        = cyc + WIDTH + 2;
                    job_on         = 1;
                    ack_seen[pick] = 1'b1;
                end else begin
                    check_val("ack_none", ack, 0);
                end
            end else begin
                check_val("ack_busy", ack, 0);
                check_val("busy_job", busy, 1);
                check_val("gid_job", grant_id, exp_id);
                if (cyc == done_at) begin
                    check_val("done_pulse", done, 1);
                    check_val("ostream_ref", ostream, ref_detect(exp_word));
                    rr     = (exp_id + 1) % N_REQ;
                    job_on = 0;
                    jobs_done++;
                end else begin
                    check_val("done_quiet", done, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (ack_seen[i]) begin
                ack_seen[i] = 1'b0;
                if (!hold_req[i]) req[i] = 1'b0;
            end
        end
    endtask

    task automatic set_word(input int i, input logic [WIDTH-1:0] w);
        istream[i*WIDTH +: WIDTH] = w;
    endtask

    task automatic wait_ack(input string tag);
        bit seen;
        seen = 0;
        for (int n = 0; n < 4*WIDTH && !seen; n++) begin
            @(negedge clk);
            if (|ack) seen = 1;
        end
        check_val(tag, seen, 1);
    endtask

    task automatic wait_done(input string tag, output int cycles);
        bit seen;
        seen   = 0;
        cycles = 0;
        for (int n = 0; n < 4*WIDTH && !seen; n++) begin
            tick();
            cycles++;
            if (done) seen = 1;
        end
        check_val(tag, seen, 1);
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [31:0] r, b;
        r = $urandom();
        case ($urandom_range(0, 2))
            0:       b = r;
            1:       b = 32'hB6DB6DB6 >> r[1:0];
            default: b = 32'hDDDDDDDD ^ (32'h1 << r[4:0]);
        endcase
        return b[WIDTH-1:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        reset   = 1'b1;
        req     = '0;
        istream = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single request, latency and pattern repeat
        set_word(0, 16'hDDDD);
        req[0] = 1'b1;
        wait_ack("t1_ack_seen");
        wait_done("t1_done_seen", c);
        check_val("t1_latency", c, 18);
        check_val("t1_ostream", ostream, 16'h1111);
        check_val("t1_gid", grant_id, 0);

        set_word(1, 16'hDB6D);
        req[1] = 1'b1;
        wait_done("t2_done_seen", c);
        check_val("t2_ostream", ostream, 16'h1249);
        check_val("t2_gid", grant_id, 1);

        // Both held: strict rotation
        set_word(0, 16'hFFFF);
        set_word(1, 16'h0000);
        hold_req = 2'b11;
        req      = 2'b11;
        wait_done("t3a_done_seen", c);
        check_val("t3a_gid", grant_id, 0);
        check_val("t3a_ostream", ostream, 16'h0000);
        wait_done("t3b_done_seen", c);
        check_val("t3b_gid", grant_id, 1);
        check_val("t3b_ostream", ostream, 16'h0000);
        wait_ack("t3c_ack_seen");
        check_val("t3c_ack", ack, 2'b01);
        hold_req = '0;
        tick();
        req = '0;
        wait_done("t3c_done_seen", c);

        // Back-to-back; the second word is written right after the first ack
        set_word(0, 16'h000D);
        req[0] = 1'b1;
        wait_ack("t4_ack_seen");
        tick();
        set_word(0, 16'hD000);
        req[0] = 1'b1;
        wait_done("t4a_done_seen", c);
        check_val("t4a_ostream", ostream, 16'h0001);
        wait_done("t4b_done_seen", c);
        check_val("t4b_ostream", ostream, 16'h1000);

        set_word(0, 16'h0DDD);
        req[0] = 1'b1;
        wait_ack("t5_ack_seen");
        tick();
        set_word(0, 16'hFFFF);
        wait_done("t5_done_seen", c);
        check_val("t5_ostream", ostream, 16'h0111);

        // Reset in the middle of SHIFT
        set_word(0, 16'hDDDD);
        req[0] = 1'b1;
        wait_ack("t6_ack_seen");
        repeat (6) tick();
        reset = 1'b1;
        #1;
        check_val("t6_busy", busy, 0);
        check_val("t6_ostream", ostream, 0);
        check_val("t6_gid", grant_id, 0);
        check_val("t6_done", done, 0);
        set_word(0, 16'h000D);
        req[0] = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        wait_done("t6_done_seen", c);
        check_val("t6_post_ostream", ostream, 16'h0001);
        check_val("t6_post_gid", grant_id, 0);

        // Random traffic, checked by the monitor model
        for (int n = 0; n < 600; n++) begin
            tick();
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_word(i, rand_word());
                    req[i] = 1'b1;
                end else if ($urandom_range(0, 7) == 0) begin
                    set_word(i, rand_word());
                end
            end
        end
        req = '0;
        for (int n = 0; n < 4*WIDTH && job_on; n++) tick();
        check_val("drain_idle", job_on, 0);
        check_val("jobs_progress", jobs_done > 20, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
